// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: prioritised stall/bubble/flush controls plus the HI/LO mult/div busy sequencer.
// Optional stall-cycle performance counter enabled by defining STALL_PERF_COUNTER_EN.
module hazard_scheduler #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stallReqD,
    input  logic        stallReqE,
    input  logic        mdUseD,
    input  logic        mdStartE,
    input  logic        mdDivE,
    input  logic        flushReq,
    input  logic        perfClear,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        bubbleE,
    output logic        bubbleM,
    output logic        flushD,
    output logic        flushE,
    output logic        mdBusy,
    output logic        mdDone,
    output logic [7:0]  mdCount,
    output logic [31:0] stallCycles
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PERF_W = 32;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q,  done_d;
    logic               haz_d;
    logic               md_accept;

    assign mdBusy  = (state_q == MD_BUSY);
    assign mdCount = count_q;
    assign mdDone  = done_q;

    // A HI/LO user in D must wait for both an in-flight op and one starting right now in E.
    assign haz_d = stallReqD | (mdUseD & (mdBusy | mdStartE));

    // Fixed-priority stall/bubble/flush decode: flush > E stall > D hazard.
    always_comb begin
        stallF  = 1'b0;
        stallD  = 1'b0;
        stallE  = 1'b0;
        bubbleE = 1'b0;
        bubbleM = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        if (flushReq) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (stallReqE) begin
            stallF  = 1'b1;
            stallD  = 1'b1;
            stallE  = 1'b1;
            bubbleM = 1'b1;
        end else if (haz_d) begin
            stallF  = 1'b1;
            stallD  = 1'b1;
            bubbleE = 1'b1;
        end
    end

    assign md_accept = mdStartE & ~stallE & ~flushReq;

    // Sequencer next state; a start seen while busy is a decoder fault and is dropped.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (md_accept) begin
                    count_d = mdDivE ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (count_q == CNT_W'(1)) begin
                    count_d = '0;
                    done_d  = 1'b1;
                    state_d = MD_IDLE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: begin
                count_d = '0;
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

`ifdef STALL_PERF_COUNTER_EN
    logic [PERF_W-1:0] perf_q, perf_d;

    // Clear wins over increment; increment wraps naturally at 2^32.
    always_comb begin
        perf_d = perf_q;
        if (perfClear) begin
            perf_d = '0;
        end else if (stallF) begin
            perf_d = perf_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign stallCycles = perf_q;
`else
    logic unused_perf_clear;
    assign unused_perf_clear = perfClear;
    assign stallCycles       = PERF_W'(0);
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed self-checking bench for hazard_scheduler with default parameters.
module tb_hazard_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stallReqD, stallReqE, mdUseD, mdStartE, mdDivE, flushReq, perfClear;
    logic        stallF, stallD, stallE, bubbleE, bubbleM, flushD, flushE;
    logic        mdBusy, mdDone;
    logic [7:0]  mdCount;
    logic [31:0] stallCycles;
    logic [6:0]  ctl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n),
        .stallReqD(stallReqD), .stallReqE(stallReqE), .mdUseD(mdUseD),
        .mdStartE(mdStartE), .mdDivE(mdDivE), .flushReq(flushReq), .perfClear(perfClear),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .bubbleE(bubbleE),
        .bubbleM(bubbleM), .flushD(flushD), .flushE(flushE),
        .mdBusy(mdBusy), .mdDone(mdDone), .mdCount(mdCount), .stallCycles(stallCycles)
    );

    // {stallF, stallD, stallE, bubbleE, bubbleM, flushD, flushE}
    assign ctl = {stallF, stallD, stallE, bubbleE, bubbleM, flushD, flushE};

    task automatic clear_inputs();
        stallReqD = 1'b0; stallReqE = 1'b0; mdUseD = 1'b0; mdStartE = 1'b0;
        mdDivE = 1'b0; flushReq = 1'b0; perfClear = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        #2;
        n_checks++;
        if (ctl !== 7'b0 || mdBusy !== 1'b0 || mdCount !== 8'd0 || mdDone !== 1'b0 || stallCycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_held: ctl=%b busy=%b cnt=%0d done=%b perf=%0d expected all zero", ctl, mdBusy, mdCount, mdDone, stallCycles);
        end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl !== 7'b0 || mdBusy !== 1'b0 || mdCount !== 8'd0 || mdDone !== 1'b0 || stallCycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_release: ctl=%b busy=%b cnt=%0d done=%b perf=%0d expected all zero", ctl, mdBusy, mdCount, mdDone, stallCycles);
        end
    endtask

    task automatic test_mult();
        next_cycle();
        mdStartE = 1'b1; mdDivE = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mdBusy !== 1'b0 || ctl !== 7'b0) begin
            n_fail++;
            $display("FAIL mult_start_cycle: busy=%b ctl=%b expected busy=0 ctl=0000000", mdBusy, ctl);
        end
        next_cycle();
        mdStartE = 1'b0;
        for (int i = 5; i >= 1; i--) begin
            @(negedge clk);
            n_checks++;
            if (mdBusy !== 1'b1 || mdCount !== 8'(i) || mdDone !== 1'b0) begin
                n_fail++;
                $display("FAIL mult_busy_%0d: busy=%b cnt=%0d done=%b expected busy=1 cnt=%0d done=0", i, mdBusy, mdCount, mdDone, i);
            end
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (mdDone !== 1'b1 || mdBusy !== 1'b0 || mdCount !== 8'd0) begin
            n_fail++;
            $display("FAIL mult_done: done=%b busy=%b cnt=%0d expected done=1 busy=0 cnt=0", mdDone, mdBusy, mdCount);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (mdDone !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_done_pulse: done=%b expected 0", mdDone);
        end
    endtask

    task automatic test_div_interlock();
        int  stalls = 0;
        bit  seen   = 1'b0;
        next_cycle();
        mdStartE = 1'b1; mdDivE = 1'b1; mdUseD = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl !== 7'b1101000) begin
            n_fail++;
            $display("FAIL div_start_ctl: ctl=%b expected 1101000", ctl);
        end
        if (stallF === 1'b1) stalls++;
        next_cycle();
        mdStartE = 1'b0; mdDivE = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mdDone === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (stallF === 1'b1) stalls++;
            next_cycle();
        end
        n_checks++;
        if (seen !== 1'b1 || stalls != 11) begin
            n_fail++;
            $display("FAIL div_interlock_len: done_seen=%b stall_cycles=%0d expected done_seen=1 stall_cycles=11", seen, stalls);
        end
        n_checks++;
        if (ctl !== 7'b0 || mdBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL div_release: ctl=%b busy=%b expected ctl=0000000 busy=0", ctl, mdBusy);
        end
        mdUseD = 1'b0;
    endtask

    task automatic test_priority();
        next_cycle();
        stallReqE = 1'b1; stallReqD = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl !== 7'b1110100) begin
            n_fail++;
            $display("FAIL prio_stallE: ctl=%b expected 1110100", ctl);
        end
        flushReq = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 7'b0000011) begin
            n_fail++;
            $display("FAIL prio_flush: ctl=%b expected 0000011", ctl);
        end
        clear_inputs();
        stallReqD = 1'b1;
        #1;
        n_checks++;
        if (ctl !== 7'b1101000) begin
            n_fail++;
            $display("FAIL prio_stallD: ctl=%b expected 1101000", ctl);
        end
        clear_inputs();
        #1;
        n_checks++;
        if (ctl !== 7'b0) begin
            n_fail++;
            $display("FAIL prio_idle: ctl=%b expected 0000000", ctl);
        end
    endtask

    task automatic test_accept_block();
        bit seen = 1'b0;
        next_cycle();
        mdStartE = 1'b1; flushReq = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl !== 7'b0000011) begin
            n_fail++;
            $display("FAIL blk_flush_ctl: ctl=%b expected 0000011", ctl);
        end
        next_cycle();
        flushReq = 1'b0; stallReqE = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mdBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL blk_flush_accept: busy=%b expected 0", mdBusy);
        end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (mdBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL blk_stallE_1: busy=%b expected 0", mdBusy);
        end
        next_cycle();
        stallReqE = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mdBusy !== 1'b0) begin
            n_fail++;
            $display("FAIL blk_stallE_2: busy=%b expected 0", mdBusy);
        end
        next_cycle();
        mdStartE = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mdBusy !== 1'b1 || mdCount !== 8'd5) begin
            n_fail++;
            $display("FAIL blk_late_accept: busy=%b cnt=%0d expected busy=1 cnt=5", mdBusy, mdCount);
        end
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            @(negedge clk);
            if (mdDone === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL blk_drain: done_seen=%b expected 1", seen);
        end
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        next_cycle();
        mdStartE = 1'b1; mdDivE = 1'b0;
        next_cycle();
        mdStartE = 1'b0;
        next_cycle();
        next_cycle();
        n_checks++;
        if (mdCount !== 8'd3 || mdBusy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: cnt=%0d busy=%b expected cnt=3 busy=1", mdCount, mdBusy);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if (mdCount !== 8'd0 || mdBusy !== 1'b0 || mdDone !== 1'b0 || stallCycles !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_async: cnt=%0d busy=%b done=%b perf=%0d expected all zero", mdCount, mdBusy, mdDone, stallCycles);
        end
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mdDone !== 1'b0 || mdBusy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_no_done: stray done/busy=%b expected 0", bad);
        end
    endtask

    task automatic test_perf();
        next_cycle();
        clear_inputs();
        perfClear = 1'b1;
        next_cycle();
        perfClear = 1'b0; stallReqD = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        stallReqD = 1'b0;
        @(negedge clk);
`ifdef STALL_PERF_COUNTER_EN
        n_checks++;
        if (stallCycles !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_count: stallCycles=%0d expected 3", stallCycles);
        end
        perfClear = 1'b1; stallReqD = 1'b1;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (stallCycles !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_clear: stallCycles=%0d expected 0", stallCycles);
        end
`else
        n_checks++;
        if (stallCycles !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_disabled: stallCycles=%0d expected 0", stallCycles);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_interlock();
        test_priority();
        test_accept_block();
        test_reset_mid();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
